// File: rtl/booth_pkg.sv
// Shared types and helpers for the Booth iteration sequencer.
// Holds the state encoding, the iteration-count function and the stall counter width.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } booth_seq_state_t;

  localparam int STALL_CNT_W = 16;

  // Radix-4 retires two bits per step; odd widths round up.
  function automatic int unsigned iter_count(
    input int unsigned width,
    input logic        radix4
  );
    return radix4 ? (width + 1) >> 1 : width;
  endfunction

endpackage

// File: rtl/booth_sat_cnt.sv
// Saturating up-counter with synchronous clear and increment enable.
// Used for the optional stall statistics of the Booth sequencer.
module booth_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/booth_iter_seq.sv
// Iteration sequencer for the Booth multiplier datapath (start/busy/done, stall, abort).
// Optional stall statistics output under macro BOOTH_ITER_STALL_STAT_EN.
module booth_iter_seq
  import booth_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 radix4,
  input  logic                 stall,
  input  logic                 abort,
  output logic                 step_en,
  output logic                 last,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] count
`ifdef BOOTH_ITER_STALL_STAT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  localparam logic [CNT_WIDTH-1:0] N_R2 =
    CNT_WIDTH'(iter_count(DATA_WIDTH, 1'b0));
  localparam logic [CNT_WIDTH-1:0] N_R4 =
    CNT_WIDTH'(iter_count(DATA_WIDTH, 1'b1));
  localparam logic [CNT_WIDTH-1:0] ONE =
    CNT_WIDTH'(1);

  booth_seq_state_t     state;
  booth_seq_state_t     state_nxt;
  logic [CNT_WIDTH-1:0] count_nxt;
  logic [CNT_WIDTH-1:0] n_sel;
  logic                 accept;

  assign n_sel = radix4 ? N_R4 : N_R2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          accept    = 1'b1;
          state_nxt = RUN;
          count_nxt = n_sel;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end else if (!stall) begin
          count_nxt = count - ONE;
          if (count == ONE) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (abort) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end else if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
          count_nxt = n_sel;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
  end

  // Outputs decode straight from state so an async reset drops them at once.
  assign busy    = (state == RUN);
  assign step_en = busy && !stall;
  assign last    = step_en && (count == ONE);
  assign done    = (state == DONE) && !abort;

`ifdef BOOTH_ITER_STALL_STAT_EN
  booth_sat_cnt #(
    .W (STALL_CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .inc   (busy && stall),
    .value (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_booth_iter_seq.sv
// Scoreboard bench for booth_iter_seq (DATA_WIDTH 8 and 7 instances).
// Stimulus pushes expected runs; a negedge monitor checks them at done.
module tb_booth_iter_seq;
  import booth_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic start7 = 1'b0;
  logic radix4 = 1'b0;
  logic stall = 1'b0;
  logic abort = 1'b0;

  logic [1:0] step_en;
  logic [1:0] last;
  logic [1:0] busy;
  logic [1:0] done;
  logic [3:0] count8;
  logic [2:0] count7;
`ifdef BOOTH_ITER_STALL_STAT_EN
  logic [15:0] scnt [2];
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int n;
    int done_cyc;
    int stalls;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  booth_iter_seq #(.DATA_WIDTH(8)) u8 (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .radix4  (radix4),
    .stall   (stall),
    .abort   (abort),
    .step_en (step_en[0]),
    .last    (last[0]),
    .busy    (busy[0]),
    .done    (done[0]),
    .count   (count8)
`ifdef BOOTH_ITER_STALL_STAT_EN
    ,
    .stall_cnt (scnt[0])
`endif
  );

  booth_iter_seq #(.DATA_WIDTH(7)) u7 (
    .clk     (clk),
    .rst     (rst),
    .start   (start7),
    .radix4  (radix4),
    .stall   (stall),
    .abort   (abort),
    .step_en (step_en[1]),
    .last    (last[1]),
    .busy    (busy[1]),
    .done    (done[1]),
    .count   (count7)
`ifdef BOOTH_ITER_STALL_STAT_EN
    ,
    .stall_cnt (scnt[1])
`endif
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push0(input int n, input int s);
    q0.push_back('{n, cyc + n + 1 + s, s});
  endtask

  task automatic push1(input int n, input int s);
    q1.push_back('{n, cyc + n + 1 + s, s});
  endtask

  int   steps [2];
  int   lasts [2];
  int   n0 [2];
  int   prevc [2];
  logic pbusy [2];
  int   c;
  int   qs;
  exp_t e;

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        pbusy[i] = 1'b0;
        steps[i] = 0;
        lasts[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        c  = (i == 0) ? int'(count8) : int'(count7);
        qs = (i == 0) ? q0.size() : q1.size();
        if (busy[i] && !pbusy[i]) begin
          steps[i] = 0;
          lasts[i] = 0;
        end
        if (busy[i] && stall)
          chk($sformatf("stall_gate%0d", i), 32'(step_en[i]), 0);
        if (step_en[i]) begin
          if (steps[i] == 0) n0[i] = c;
          else chk($sformatf("count_dec%0d", i), c, prevc[i] - 1);
          prevc[i] = c;
          steps[i]++;
          if (last[i]) begin
            lasts[i]++;
            chk($sformatf("last_at_one%0d", i), c, 1);
          end
        end
        if (done[i]) begin
          if (qs == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done%0d: done at cycle %0d, required none",
                     i, cyc);
          end else begin
            if (i == 0) e = q0.pop_front();
            else e = q1.pop_front();
            chk($sformatf("steps%0d", i), steps[i], e.n);
            chk($sformatf("first_count%0d", i), n0[i], e.n);
            chk($sformatf("last_pulses%0d", i), lasts[i], 1);
            chk($sformatf("done_cycle%0d", i), cyc, e.done_cyc);
`ifdef BOOTH_ITER_STALL_STAT_EN
            chk($sformatf("stall_cnt%0d", i), 32'(scnt[i]), e.stalls);
`endif
          end
        end
        pbusy[i] = busy[i];
      end
    end
  end

  initial begin
    step(2);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_step_en", 32'(step_en), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_last", 32'(last), 0);
    chk("rst_count8", 32'(count8), 0);
    chk("rst_count7", 32'(count7), 0);
`ifdef BOOTH_ITER_STALL_STAT_EN
    chk("rst_stall_cnt", 32'(scnt[0]), 0);
`endif
    rst = 1'b1;
    step(2);

    // radix-2 plain run
    radix4 = 1'b0;
    start = 1'b1;
    push0(8, 0);
    step();
    start = 1'b0;
    chk("t1_busy", 32'(busy[0]), 1);
    chk("t1_count_first", 32'(count8), 8);
    step(9);
    chk("t1_idle_busy", 32'(busy[0]), 0);
    chk("t1_idle_count", 32'(count8), 0);

    // radix-4, both widths, radix4 toggled mid-run
    radix4 = 1'b1;
    start = 1'b1;
    start7 = 1'b1;
    push0(4, 0);
    push1(4, 0);
    step();
    start = 1'b0;
    start7 = 1'b0;
    chk("t2_count7", 32'(count7), 4);
    step();
    radix4 = 1'b0;
    step(6);

    // stall on cycles 3 and 4
    start = 1'b1;
    push0(8, 2);
    step();
    start = 1'b0;
    step(2);
    stall = 1'b1;
    chk("t3_count_c3", 32'(count8), 6);
    step();
    chk("t3_count_c4", 32'(count8), 6);
    step();
    stall = 1'b0;
    step(7);

    // abort at cycle 4, restart two cycles later
    start = 1'b1;
    step();
    start = 1'b0;
    step(3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t4_busy", 32'(busy[0]), 0);
    chk("t4_count", 32'(count8), 0);
    chk("t4_done", 32'(done[0]), 0);
    step();
    start = 1'b1;
    push0(8, 0);
    step();
    start = 1'b0;
    step(9);
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    chk("t4_abort_start_busy", 32'(busy[0]), 0);
    chk("t4_abort_start_count", 32'(count8), 0);
    step(2);

    // start held through DONE: back-to-back runs
    start = 1'b1;
    push0(8, 0);
    q0.push_back('{8, cyc + 18, 0});
    step(9);
    chk("t5_done", 32'(done[0]), 1);
    step();
    chk("t5_step_after_done", 32'(step_en[0]), 1);
    chk("t5_reload", 32'(count8), 8);
    step();
    chk("t5_start_ignored", 32'(count8), 7);
    start = 1'b0;
    step(8);

    // async reset mid-run
    start = 1'b1;
    push0(8, 0);
    step();
    start = 1'b0;
    step(2);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_busy", 32'(busy[0]), 0);
    chk("t6_step_en", 32'(step_en[0]), 0);
    chk("t6_count", 32'(count8), 0);
    chk("t6_done", 32'(done[0]), 0);
    q0.delete();
    step(2);
    rst = 1'b1;
    step(3);
    chk("t6_idle_busy", 32'(busy[0]), 0);
    chk("t6_idle_count", 32'(count8), 0);
    radix4 = 1'b1;
    start = 1'b1;
    push0(4, 0);
    step();
    start = 1'b0;
    radix4 = 1'b0;
    step(6);

    chk("queues_drained", q0.size() + q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule
